// File: rtl/vec_pkg.sv
// -----------------------------------------------------------------------------
// vec_pkg
// Shared definitions for the image-data vector fetch/store controllers.
//   S        : word and address width (32)
//   LANES    : 32-bit words per vector (6)
//   V        : vector width, S*LANES (192)
//   ROM_SIZE : ROM depth in words; addresses >= ROM_SIZE are illegal
//   fetch_state_t : controller FSM states
//   lane_mask()   : lane k valid when k < remaining
//   clamp_count() : requested word count clipped to the end of the ROM
// -----------------------------------------------------------------------------
package vec_pkg;

  localparam int S        = 32;
  localparam int LANES    = 6;
  localparam int V        = S * LANES;
  localparam int ROM_SIZE = 30015;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DONE
  } fetch_state_t;

  function automatic logic [LANES-1:0] lane_mask(input logic [S-1:0] remaining);
    logic [LANES-1:0] m;
    m = '0;
    for (int k = 0; k < LANES; k++) begin
      m[k] = (S'(k) < remaining);
    end
    return m;
  endfunction

  // The subtraction is only evaluated for in-range bases, so it never wraps.
  function automatic logic [S-1:0] clamp_count(input logic [S-1:0] base,
                                               input logic [S-1:0] num);
    logic [S-1:0] avail;
    avail = '0;
    if (base >= S'(ROM_SIZE)) begin
      return '0;
    end
    avail = S'(ROM_SIZE) - base;
    return (num < avail) ? num : avail;
  endfunction

endpackage

// File: rtl/vec_lane_mask.sv
// -----------------------------------------------------------------------------
// vec_lane_mask
// Combinational mask-and-zero of one V-bit vector. Lane k passes through when
// k < remaining_i, otherwise it is forced to zero. Shared with the store side.
//   data_i      in  V      raw vector, lane k at bits [k*S +: S]
//   remaining_i in  S      words still owed to the transfer
//   data_o      out V      vector with unrequested lanes zeroed
//   mask_o      out LANES  per-lane valid mask
// -----------------------------------------------------------------------------
module vec_lane_mask
  import vec_pkg::*;
(
  input  logic [V-1:0]     data_i,
  input  logic [S-1:0]     remaining_i,
  output logic [V-1:0]     data_o,
  output logic [LANES-1:0] mask_o
);

  assign mask_o = lane_mask(remaining_i);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign data_o[gi*S +: S] = mask_o[gi] ? data_i[gi*S +: S] : '0;
  end

endmodule

// File: rtl/dmem_vec_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_vec_fetch_ctrl
// Streams a contiguous ROM region to the vector datapath as 6-lane vectors.
// Each vector costs one FETCH cycle (ROM read registered) plus one or more HOLD
// cycles presenting it on a valid/ready handshake.
//   clk, reset          clock, asynchronous active-high reset
//   start, abort        transfer control (start sampled only in IDLE)
//   base_addr,num_words transfer region, latched on start
//   rom_addr, rom_rd    ROM word address / combinational 6-word read data
//   vec_data, vec_mask  registered vector and its per-lane valid mask
//   vec_index           ordinal of the presented vector
//   vec_valid,vec_ready output handshake
//   busy, done          activity flag and one-cycle completion pulse
// -----------------------------------------------------------------------------
module dmem_vec_fetch_ctrl
  import vec_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [S-1:0]     base_addr,
  input  logic [S-1:0]     num_words,
  output logic [S-1:0]     rom_addr,
  input  logic [V-1:0]     rom_rd,
  output logic [V-1:0]     vec_data,
  output logic [LANES-1:0] vec_mask,
  output logic [S-1:0]     vec_index,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic             busy,
  output logic             done
);

  fetch_state_t     state_q, state_d;
  logic [S-1:0]     remaining_q, remaining_d;
  logic [S-1:0]     cur_addr_q, cur_addr_d;
  logic [S-1:0]     vec_index_q, vec_index_d;
  logic [V-1:0]     vec_data_q, vec_data_d;
  logic [LANES-1:0] vec_mask_q, vec_mask_d;

  logic [V-1:0]     masked_data;
  logic [LANES-1:0] masked_mask;
  logic [S-1:0]     start_count;
  logic [S-1:0]     take;
  logic [S-1:0]     rem_after;

  vec_lane_mask u_lane_mask (
    .data_i      (rom_rd),
    .remaining_i (remaining_q),
    .data_o      (masked_data),
    .mask_o      (masked_mask)
  );

  assign start_count = clamp_count(base_addr, num_words);
  assign take        = (remaining_q < S'(LANES)) ? remaining_q : S'(LANES);
  assign rem_after   = remaining_q - take;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cur_addr_d  = cur_addr_q;
    vec_index_d = vec_index_q;
    vec_data_d  = vec_data_q;
    vec_mask_d  = vec_mask_q;

    // Abort wins over everything, including a same-cycle handshake; the
    // presented vector registers are deliberately left untouched.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            cur_addr_d  = base_addr;
            vec_index_d = '0;
            remaining_d = start_count;
            state_d     = (start_count == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          vec_data_d = masked_data;
          vec_mask_d = masked_mask;
          state_d    = HOLD;
        end
        HOLD: begin
          if (vec_ready) begin
            remaining_d = rem_after;
            cur_addr_d  = cur_addr_q + S'(LANES);
            vec_index_d = vec_index_q + 1'b1;
            state_d     = (rem_after == '0) ? DONE : FETCH;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      cur_addr_q  <= '0;
      vec_index_q <= '0;
      vec_data_q  <= '0;
      vec_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cur_addr_q  <= cur_addr_d;
      vec_index_q <= vec_index_d;
      vec_data_q  <= vec_data_d;
      vec_mask_q  <= vec_mask_d;
    end
  end

  assign rom_addr  = cur_addr_q;
  assign vec_data  = vec_data_q;
  assign vec_mask  = vec_mask_q;
  assign vec_index = vec_index_q;
  assign vec_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_dmem_vec_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_vec_fetch_ctrl
// Directed bench with a transfer-level model: for each start it precomputes the
// list of vectors the consumer must see, and a negedge process compares every
// presented vector against the head of that list.
// -----------------------------------------------------------------------------
module tb_dmem_vec_fetch_ctrl;

  localparam int TS    = 32;
  localparam int TL    = 6;
  localparam int TV    = 192;
  localparam int TSIZE = 30015;

  logic            clk;
  logic            reset;
  logic            start;
  logic            abort;
  logic [TS-1:0]   base_addr;
  logic [TS-1:0]   num_words;
  logic [TS-1:0]   rom_addr;
  logic [TV-1:0]   rom_rd;
  logic [TV-1:0]   vec_data;
  logic [TL-1:0]   vec_mask;
  logic [TS-1:0]   vec_index;
  logic            vec_valid;
  logic            vec_ready;
  logic            busy;
  logic            done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [TV-1:0] data;
    logic [TL-1:0] mask;
    logic [TS-1:0] index;
    logic [TS-1:0] addr;
  } exp_t;

  exp_t exp_q[$];

  dmem_vec_fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .num_words (num_words),
    .rom_addr  (rom_addr),
    .rom_rd    (rom_rd),
    .vec_data  (vec_data),
    .vec_mask  (vec_mask),
    .vec_index (vec_index),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM contents; out-of-range words return recognisable junk that must be masked.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a >= 32'(TSIZE)) return 32'hBAD0_0000 | {16'h0, a[15:0]};
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  always_comb begin
    rom_rd = '0;
    for (int k = 0; k < TL; k++) begin
      rom_rd[k*32 +: 32] = rom_word(rom_addr + 32'(k));
    end
  end

  task automatic chk(input string name, input logic [TV-1:0] act, input logic [TV-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transfer-level model: which words, in what groups, with what ordinal.
  task automatic model_push(input logic [31:0] b, input logic [31:0] n);
    longint rem;
    longint take;
    exp_t   e;
    if (b >= 32'(TSIZE)) rem = 0;
    else rem = (longint'(n) < longint'(TSIZE) - longint'(b)) ? longint'(n)
                                                            : longint'(TSIZE) - longint'(b);
    for (int i = 0; rem > 0; i++) begin
      take    = (rem > TL) ? TL : rem;
      e.data  = '0;
      e.mask  = '0;
      for (int k = 0; k < take; k++) begin
        e.data[k*32 +: 32] = rom_word(b + 32'(TL*i + k));
        e.mask[k]          = 1'b1;
      end
      e.index = 32'(i);
      e.addr  = b + 32'(TL*i);
      exp_q.push_back(e);
      rem -= take;
    end
  endtask

  // Compare process: every presented vector must match the model's head;
  // a handshake (ready without abort) consumes it at the coming edge.
  always @(negedge clk) begin
    if (!reset && vec_valid) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_valid: got vec_valid=1 index=%0d expected no vector", vec_index);
      end else begin
        pass_cnt++;
        chk("vec_data",  vec_data,            exp_q[0].data);
        chk("vec_mask",  TV'(vec_mask),       TV'(exp_q[0].mask));
        chk("vec_index", TV'(vec_index),      TV'(exp_q[0].index));
        chk("rom_addr",  TV'(rom_addr),       TV'(exp_q[0].addr));
        if (vec_ready && !abort) void'(exp_q.pop_front());
      end
    end
  end

  // Start a transfer and drive ready until done; stall = ready-low cycles on
  // the first presented vector; exp_lat = edges from start sample to done.
  task automatic run_transfer(input string tag, input logic [31:0] b, input logic [31:0] n,
                              input int stall, input int exp_lat);
    int lat;
    int st;
    bit got;
    model_push(b, n);
    base_addr = b;
    num_words = n;
    start     = 1'b1;
    vec_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    st  = stall;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (vec_valid && st > 0) begin
          vec_ready = 1'b0;
          st--;
        end else begin
          vec_ready = 1'b1;
        end
        @(posedge clk); #1;
        lat++;
      end
    end
    chk({tag, "_done_seen"}, TV'(got), TV'(1));
    chk({tag, "_latency"},   TV'(lat), TV'(exp_lat));
    chk({tag, "_all_vectors_consumed"}, TV'(exp_q.size()), TV'(0));
    exp_q.delete();
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, TV'(done), TV'(0));
    chk({tag, "_idle_after"},     TV'(busy), TV'(0));
    $display("transfer %s base=%0d num=%0d stall=%0d latency=%0d index_after=%0d",
             tag, b, n, stall, lat, vec_index);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    num_words = '0;
    vec_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_rom_addr",  TV'(rom_addr),  TV'(0));
    chk("rst_vec_data",  vec_data,       TV'(0));
    chk("rst_vec_mask",  TV'(vec_mask),  TV'(0));
    chk("rst_vec_index", TV'(vec_index), TV'(0));
    chk("rst_flags",     TV'({vec_valid, busy, done}), TV'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Two full vectors: FETCH,HOLD,FETCH,HOLD then done.
    run_transfer("full", 32'd0, 32'd12, 0, 4);
    chk("full_mask_literal",  TV'(vec_mask),  TV'(6'b111111));
    chk("full_index_literal", TV'(vec_index), TV'(2));

    // Tail vector with two live lanes.
    run_transfer("tail", 32'd100, 32'd8, 0, 4);
    chk("tail_mask_literal",  TV'(vec_mask),  TV'(6'b000011));
    chk("tail_upper_zero",    vec_data[191:64], 128'h0);
    chk("tail_lane0_literal", TV'(vec_data[31:0]), TV'(rom_word(32'd106)));

    // ROM end clamp: only 3 words exist.
    run_transfer("clamp", 32'd30012, 32'd10, 0, 2);
    chk("clamp_mask_literal", TV'(vec_mask), TV'(6'b000111));
    chk("clamp_upper_zero",   vec_data[191:96], 96'h0);

    // Base past the end: straight to done, no vector.
    run_transfer("oob", 32'd30015, 32'd4, 0, 0);
    run_transfer("zero", 32'd50, 32'd0, 0, 0);

    // Seven cycles of backpressure on a single vector.
    run_transfer("bp", 32'd200, 32'd6, 7, 9);
    chk("bp_index_literal", TV'(vec_index), TV'(1));

    // Start while busy is ignored; abort beats a simultaneous handshake.
    model_push(32'd0, 32'd12);
    base_addr = 32'd0;
    num_words = 32'd12;
    start     = 1'b1;
    vec_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_hold", TV'(vec_valid), TV'(1));
    base_addr = 32'd500;
    num_words = 32'd6;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_ignored_addr",  TV'(rom_addr),  TV'(0));
    chk("busy_start_ignored_index", TV'(vec_index), TV'(0));
    abort     = 1'b1;
    vec_ready = 1'b1;
    @(posedge clk); #1;
    abort     = 1'b0;
    vec_ready = 1'b0;
    exp_q.delete();
    chk("abort_idle",      TV'({vec_valid, busy}), TV'(0));
    chk("abort_no_done",   TV'(done),      TV'(0));
    chk("abort_index",     TV'(vec_index), TV'(0));
    chk("abort_mask_kept", TV'(vec_mask),  TV'(6'b111111));
    chk("abort_data_kept", TV'(vec_data[31:0]), TV'(rom_word(32'd0)));
    @(posedge clk); #1;
    chk("abort_no_late_done", TV'(done), TV'(0));
    $display("transfer abort index=%0d busy=%0d", vec_index, busy);

    // Asynchronous reset in the middle of FETCH.
    base_addr = 32'd6;
    num_words = 32'd12;
    start     = 1'b1;
    vec_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("pre_reset_busy", TV'(busy), TV'(1));
    #2 reset = 1'b1;
    #1;
    chk("async_rst_data",  vec_data,       TV'(0));
    chk("async_rst_addr",  TV'(rom_addr),  TV'(0));
    chk("async_rst_mask",  TV'(vec_mask),  TV'(0));
    chk("async_rst_index", TV'(vec_index), TV'(0));
    chk("async_rst_flags", TV'({vec_valid, busy, done}), TV'(0));
    $display("transfer reset mid-fetch flags=%b", {vec_valid, busy, done});
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post_reset_no_done", TV'(done), TV'(0));
    @(posedge clk); #1;

    run_transfer("recover", 32'd18, 32'd7, 0, 4);
    chk("recover_mask_literal", TV'(vec_mask), TV'(6'b000001));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
